// File: rtl/dm_resp_pkg.sv
// Shared types, defaults and sizing helper for the data-memory responder.
package dm_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned DEFAULT_LATENCY     = 2;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dm_resp_array.sv
// Word-organised storage: one byte-enabled write port, one async read port,
// whole array cleared by the asynchronous active-low reset.
module dm_resp_array
  import dm_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned AW          = idx_width(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[AW'(i)] <= '0;
    end else if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one request at a time, performs the access
// LATENCY cycles later and holds the response until the consumer takes it.
module dm_responder
  import dm_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = idx_width(DEPTH_WORDS);

  state_t        state, state_nx;
  logic [2:0]    cnt;
  logic          l_we;
  logic [31:0]   l_addr, l_wdata, l_pc;
  logic [3:0]    l_be;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word, merged;
  logic          accept, access, addr_err, mem_we;

  assign req_ready  = (state == IDLE) && reset;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign access     = (state == BUSY) && (cnt == '0);
  assign idx        = l_addr[AW+1:2];
  assign addr_err   = (l_addr[1:0] != 2'b00) || (l_addr[31:2] >= 30'(DEPTH_WORDS));
  assign mem_we     = access && l_we && !addr_err;

  always_comb begin
    merged = rd_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (l_be[b]) merged[8*b +: 8] = l_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (cnt == '0) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      l_we       <= 1'b0;
      l_addr     <= '0;
      l_be       <= '0;
      l_wdata    <= '0;
      l_pc       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= 3'(LATENCY - 1);
        l_we    <= req_we;
        l_addr  <= req_addr;
        l_be    <= req_be;
        l_wdata <= req_wdata;
        l_pc    <= req_pc;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      // Response fields are captured once at the access edge and then held.
      if (access) begin
        resp_rdata <= (l_we || addr_err) ? '0 : rd_word;
        resp_err   <= addr_err;
`ifndef SYNTHESIS
        if (mem_we) $display("@%08h: *%08h <= %08h", l_pc, l_addr, merged);
`endif
      end else if (state == RESP && resp_ready) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

  dm_resp_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (idx),
    .be    (l_be),
    .wdata (l_wdata),
    .raddr (idx),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_dm_responder.sv
// Randomised self-checking bench for dm_responder with a transaction-level
// reference model, plus directed scenarios and a LATENCY=1 instance.
module tb_dm_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid1 = 1'b0, req_we1 = 1'b0, resp_ready1 = 1'b0;
  logic [31:0] req_addr1 = '0, req_wdata1 = '0, req_pc1 = '0;
  logic [3:0]  req_be1 = '0;
  logic        req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .req_pc(req_pc), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1), .req_be(req_be1), .req_wdata(req_wdata1),
    .req_pc(req_pc1), .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction timestamps) ----------------
  bit [31:0]   m_mem [int unsigned];
  bit          m_busy = 1'b0;
  int unsigned m_acc = 0;
  int unsigned ecount = 0;
  bit          m_we, m_err;
  bit [31:0]   m_addr, m_wdata, m_rdata;
  bit [3:0]    m_be;

  function automatic bit [31:0] m_read(input int unsigned w);
    return m_mem.exists(w) ? m_mem[w] : 32'h0;
  endfunction

  always @(negedge reset) begin
    m_busy = 1'b0;
    m_mem.delete();
  end

  always @(posedge clk) begin
    bit [31:0] word;
    ecount++;
    if (reset) begin
      if (!m_busy) begin
        if (req_valid) begin
          m_busy  = 1'b1;
          m_acc   = ecount;
          m_we    = req_we;
          m_addr  = req_addr;
          m_be    = req_be;
          m_wdata = req_wdata;
          m_err   = (req_addr % 4 != 0) || (req_addr >= 4 * DEPTH);
          m_rdata = (req_we || m_err) ? 32'h0 : m_read(req_addr / 4);
        end
      end else begin
        if (ecount == m_acc + LAT && m_we && !m_err) begin
          word = m_read(m_addr / 4);
          for (int b = 0; b < 4; b++)
            if (m_be[b]) word[8*b +: 8] = m_wdata[8*b +: 8];
          m_mem[m_addr / 4] = word;
        end
        if (ecount > m_acc + LAT && resp_ready) m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_ready, exp_valid;
    exp_ready = reset && !m_busy;
    exp_valid = reset && m_busy && (ecount >= m_acc + LAT);
    chk("req_ready", req_ready, exp_ready);
    chk("resp_valid", resp_valid, exp_valid);
    if (exp_valid || !reset) begin
      chk("resp_rdata", resp_rdata, exp_valid ? m_rdata : 32'h0);
      chk("resp_err", resp_err, exp_valid ? m_err : 1'b0);
    end
  end

  // ---------------- driver ----------------
  task automatic txn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input logic [31:0] pc,
                     input int unsigned delay, input bit hold_valid,
                     output logic [31:0] rd, output logic er,
                     output int unsigned lat, output int unsigned waits);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be;
    req_wdata = wdata; req_pc = pc; resp_ready = 1'b0;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 20) begin waits++; @(negedge clk); end
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
    req_we = 1'($urandom); req_addr = $urandom; req_be = 4'($urandom);
    req_wdata = $urandom; req_pc = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
    if (!resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    lat = lat - 1;
    rd = resp_rdata; er = resp_err;
    repeat (delay) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int unsigned lat, w;

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 32'd0);
    chk("rst_ready1", req_ready1, 32'd0);
    chk("rst_valid1", resp_valid1, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // store then load of the same word
    txn(1'b1, 32'h10, 4'hF, 32'h12345678, 32'h3004, 0, 1'b0, rd, er, lat, w);
    chk("st_lat", lat, 32'd2); chk("st_err", er, 32'd0); chk("st_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 4'h0, 32'h0, 32'h0, 0, 1'b0, rd, er, lat, w);
    chk("ld_lat", lat, 32'd2); chk("ld_rdata", rd, 32'h12345678); chk("ld_err", er, 32'd0);

    // partial byte-lane store
    txn(1'b1, 32'h10, 4'b0010, 32'h0000AB00, 32'h3008, 1, 1'b0, rd, er, lat, w);
    txn(1'b0, 32'h10, 4'hF, 32'h0, 32'h0, 0, 1'b0, rd, er, lat, w);
    chk("be_rdata", rd, 32'h1234AB78);

    // misaligned / out of range
    txn(1'b0, 32'h11, 4'hF, 32'h0, 32'h0, 0, 1'b0, rd, er, lat, w);
    chk("mis_err", er, 32'd1); chk("mis_rdata", rd, 32'd0);
    txn(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 32'h300C, 0, 1'b0, rd, er, lat, w);
    chk("oor_err", er, 32'd1); chk("oor_rdata", rd, 32'd0);
    txn(1'b0, 32'h0, 4'hF, 32'h0, 32'h0, 0, 1'b0, rd, er, lat, w);
    chk("oor_alias_rdata", rd, 32'd0); chk("oor_alias_err", er, 32'd0);

    // consumer stall with req_valid held high
    txn(1'b0, 32'h10, 4'hF, 32'h0, 32'h0, 5, 1'b1, rd, er, lat, w);
    chk("stall_rdata", rd, 32'h1234AB78);
    txn(1'b0, 32'h10, 4'hF, 32'h0, 32'h0, 0, 1'b0, rd, er, lat, w);
    chk("accept_after_consume", w, 32'd0);

    // reset during BUSY of a store to 0x20
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF;
    req_wdata = 32'hCAFEF00D; req_pc = 32'h3010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    txn(1'b0, 32'h20, 4'hF, 32'h0, 32'h0, 0, 1'b0, rd, er, lat, w);
    chk("rst_abandon_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 4'hF, 32'h0, 32'h0, 0, 1'b0, rd, er, lat, w);
    chk("rst_clear_rdata", rd, 32'd0);

    // randomised traffic
    for (int n = 0; n < 120; n++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, 15)) * 4;
      else if (r == 8) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else             a = 4 * DEPTH + 32'($urandom_range(0, 1000)) * 4;
      txn(1'($urandom), a, 4'($urandom), $urandom, $urandom,
          $urandom_range(0, 3), 1'($urandom), rd, er, lat, w);
    end

    // LATENCY=1: back-to-back loads with resp_ready tied high
    @(posedge clk); #1;
    req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = 32'h40; resp_ready1 = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk("l1_ready", req_ready1, (j % 3 == 0) ? 32'd1 : 32'd0);
      chk("l1_valid", resp_valid1, (j % 3 == 2) ? 32'd1 : 32'd0);
      if (j % 3 == 2) begin
        chk("l1_rdata", resp_rdata1, 32'd0);
        chk("l1_err", resp_err1, 32'd0);
      end
    end
    req_valid1 = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
